// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock over a
// start/ready handshake, with a one-cycle done pulse and a divide-by-zero flag.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH:0]   r_q, r_nx;
  logic [WIDTH-1:0] q_q, q_nx;
  logic [WIDTH-1:0] d_q, d_nx;
  logic [CW-1:0]    cnt_q, cnt_nx;
  logic [WIDTH-1:0] quo_nx, rem_nx;
  logic             dbz_nx;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH+1:0] trial;

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    r_sh  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    q_sh  = {q_q[WIDTH-2:0], 1'b0};
    // The extra top bit of trial is the borrow: set when the shifted
    // remainder is smaller than the divisor.
    trial = {1'b0, r_sh} - {2'b00, d_q};

    state_nx = state;
    r_nx     = r_q;
    q_nx     = q_q;
    d_nx     = d_q;
    cnt_nx   = cnt_q;
    quo_nx   = quotient;
    rem_nx   = remainder;
    dbz_nx   = div_by_zero;

    case (state)
      IDLE: begin
        if (start) begin
          q_nx   = dividend;
          d_nx   = divisor;
          r_nx   = '0;
          cnt_nx = '0;
          if (divisor == '0) begin
            state_nx = DONE;
            quo_nx   = '1;
            rem_nx   = dividend;
            dbz_nx   = 1'b1;
          end else begin
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        if (!trial[WIDTH+1]) begin
          r_nx = trial[WIDTH:0];
          q_nx = {q_sh[WIDTH-1:1], 1'b1};
        end else begin
          r_nx = r_sh;
          q_nx = q_sh;
        end
        cnt_nx = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_nx = DONE;
          quo_nx   = q_nx;
          rem_nx   = r_nx[WIDTH-1:0];
          dbz_nx   = 1'b0;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nx;
      r_q         <= r_nx;
      q_q         <= q_nx;
      d_q         <= d_nx;
      cnt_q       <= cnt_nx;
      quotient    <= quo_nx;
      remainder   <= rem_nx;
      div_by_zero <= dbz_nx;
    end
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider, the inverse of the team's doubling multiplier datapath. It accepts a dividend/divisor pair over a start/ready handshake. It resolves one quotient bit per clock and presents quotient and remainder with a one-cycle done pulse. It sits beside the multiplier as the arithmetic block that undoes scaling, for example recovering a count from a multiplied value.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clk, accepted only when ready=1
- dividend  input  WIDTH  unsigned numerator; sampled on the accepting edge only
- divisor  input  WIDTH  unsigned denominator; sampled on the accepting edge only
- ready  output  1  high in IDLE; block can accept start
- done  output  1  one-cycle pulse; quotient/remainder valid
- quotient  output  WIDTH  registered result; held until the next completion
- remainder  output  WIDTH  registered result; held until the next completion
- div_by_zero  output  1  registered flag for the last completed operation

## Operation
- States: IDLE, RUN, DONE. All registers are driven from one sequential process; next-state and datapath logic are combinational.
- IDLE:
  - ready=1.
  - start=1 at an edge latches dividend into shift register Q (WIDTH bits), divisor into D, and clears partial remainder R (WIDTH+1 bits) and bit counter.
  - If divisor≠0, go to RUN. If divisor=0, go to DONE directly.
- RUN: each edge performs one step:
  - {R,Q} is shifted left 1.
  - trial = R − {0,D}.
  - If trial ≥ 0, R=trial and Q[0]=1; otherwise Q[0]=0.
  - The counter increments. After the WIDTH-th step, go to DONE.
- On the edge entering DONE:
  - Normal case: quotient←Q, remainder←R[WIDTH-1:0], div_by_zero←0.
  - Zero-divisor case: quotient←all ones, remainder←dividend, div_by_zero←1.
- DONE: done=1 and ready=0 for exactly one cycle, then unconditionally return to IDLE.
- start while ready=0 (RUN or DONE) is ignored: no queueing, no restart, operands not sampled.
- dividend/divisor may change freely after the accepting edge without affecting the operation in flight.
- quotient, remainder and div_by_zero change only on entry to DONE or on reset.
- Arithmetic: unsigned only. Invariant for divisor≠0: dividend = quotient·divisor + remainder, with remainder < divisor. No overflow is possible.

## Timing
- Reset (asynchronous, immediate, mid-operation included):
  - State=IDLE.
  - ready=1, done=0, quotient=0, remainder=0, div_by_zero=0.
  - R, Q, D and counter are cleared; the in-flight operation is discarded with no done pulse.
- Accepting edge E0 (start=1, ready=1): ready falls after E0.
- divisor≠0: RUN steps on edges E1..E_WIDTH. done=1 in the cycle after E_WIDTH, so latency is WIDTH cycles (8 for the default) from the accepting edge to the done cycle. ready returns high one cycle after done.
- divisor=0: done=1 in the cycle immediately after E0 (latency 1).
- Throughput: at most one operation per WIDTH+2 cycles. Back-to-back requests are possible: start held high is accepted on the first edge with ready=1 after DONE.
- Release of rst takes effect on the first subsequent edge. start coincident with reset release is accepted only if rst is already low at that edge.

## Test plan
- Normal division: reset, then start with 100/7 → done pulses exactly 8 cycles after the accepting edge; quotient=14, remainder=2, div_by_zero=0; ready=1 one cycle later.
- Operand edge cases:
  - 255/1 → quotient=255, remainder=0.
  - 5/9 → quotient=0, remainder=5.
  - 0/3 → quotient=0, remainder=0.
  - 128/128 → quotient=1, remainder=0.
- Divide by zero: 77/0 → done 1 cycle after acceptance; quotient=255, remainder=77, div_by_zero=1. A following 9/3 → quotient=3, remainder=0, div_by_zero=0.
- Busy and operand isolation:
  - Start 200/3, then pulse start with 50/5 in RUN cycle 3 and change the operand inputs → single done with quotient=66, remainder=2; the second request is ignored.
  - With start held high continuously, a second operation is accepted on the first edge ready=1 after done.
- Reset mid-operation: assert rst in RUN cycle 4 of 99/4 → all outputs are immediately 0 and ready=1, with no done pulse. A new 99/4 afterwards → quotient=24, remainder=3.
- Exhaustive check: all dividend/divisor pairs for WIDTH=8 against a reference model. Each operation must satisfy the invariant and produce exactly one done pulse.
